uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
Oversampling UART receiver that deserializes the serial RX line into bytes for the system controller. It produces a one-cycle-valid byte (P_DATA/DATA_VLD), which the system controller consumes as its UART_RX_DATA/UART_RX_VLD command and operand stream. It runs in the UART RX clock domain at PRESCALE times the bit rate. It flags parity and stop-bit errors and drops those frames.

Parameters:
DATA_WIDTH, 8, payload bits per frame, sent LSB first
PRESCALE_W, 6, width of the PRESCALE input

Ports:
CLK  in  1  UART RX oversampling clock
RST  in  1  synchronous active-high reset
RX_IN  in  1  asynchronous serial line, idles high
PRESCALE  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = parity bit present between data and stop
PAR_TYP  in  1  0 = even, 1 = odd
P_DATA  out  DATA_WIDTH  last good received byte
DATA_VLD  out  1  one-cycle pulse, P_DATA valid
PAR_ERR  out  1  one-cycle pulse, parity mismatch
STP_ERR  out  1  one-cycle pulse, stop bit sampled low

Behaviour:
- Reset: RST high at a CLK edge forces the following.
  - State IDLE; all counters 0.
  - P_DATA=0, DATA_VLD=0, PAR_ERR=0, STP_ERR=0.
  - Synchronizer flops set to 1.
  - Reset mid-frame discards the partial frame; no error pulse is produced.
- Input synchronization: RX_IN passes through a 2-flop synchronizer to give RX_S. All timing below refers to RX_S.
- Frame configuration: PRESCALE, PAR_EN and PAR_TYP are captured when IDLE sees RX_S=0 and are held for the whole frame. An illegal PRESCALE value is treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 within each bit period (P = captured prescale).
  - bit_cnt indexes data bits 0..DATA_WIDTH-1.
- Sampling: RX_S is sampled at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, registered at edge_cnt = P/2+2. Every decision is taken at edge_cnt = P-1.
- States:
  - IDLE: on RX_S=0 go to START; edge_cnt counts from 1 in the next cycle (the detect cycle is edge 0).
  - START: at P-1, majority=0 goes to DATA; majority=1 is a glitch and returns to IDLE with no pulse.
  - DATA: at P-1, shift the majority bit into the shift register at position bit_cnt. After bit DATA_WIDTH-1, go to PARITY if PAR_EN is set, otherwise STOP.
  - PARITY: expected bit = XOR of the data bits, XOR PAR_TYP. A mismatch sets an internal par_bad flag. At P-1, go to STOP.
  - STOP: at P-1, evaluate the frame, then return to IDLE.
- Stop-bit evaluation (outputs registered, so pulses appear in the cycle after STOP's P-1):
  - majority=0: STP_ERR=1; DATA_VLD=0; P_DATA unchanged.
  - majority=1 and par_bad: PAR_ERR=1; DATA_VLD=0; P_DATA unchanged.
  - majority=1 and parity good: P_DATA <= shift register and DATA_VLD=1 in the same cycle.
  - Simultaneous stop and parity errors: both STP_ERR and PAR_ERR pulse.
- Back-to-back frames: IDLE is re-entered at the cycle after STOP's P-1. A start bit already low there is detected immediately, with no dead cycles.
- Output timing:
  - DATA_VLD is never asserted on consecutive cycles.
  - P_DATA holds its value between pulses.
  - Frame length is (2 + DATA_WIDTH + PAR_EN) * P cycles.
  - Latency from the RX_IN start-bit fall to DATA_VLD is frame length + 2 (synchronizer) + 1 (output register).

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PRESCALE_8/16/32;
  - the parity-type encoding, shared with the TX side.
- One sub-module, uart_rx_sampler, contains edge_cnt, the three sample points, the majority vote and the bit_done strobe (edge_cnt = P-1).
- The FSM, shift register, parity check and error logic stay in the top module.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, send 0xA5 with parity bit 0 -> DATA_VLD pulses once, P_DATA=0xA5, no errors, pulse 91 cycles after the RX_IN fall (88 + 3).
- PRESCALE=16, PAR_EN=1, PAR_TYP=1, send 0x3C with parity bit 0 (wrong; odd parity needs 1) -> PAR_ERR pulse, no DATA_VLD, P_DATA keeps its previous value.
- PRESCALE=32, PAR_EN=0, send 0x7E with stop bit 0 -> STP_ERR pulse, no DATA_VLD; then RX_IN high for one bit time and send 0x81 -> DATA_VLD with P_DATA=0x81.
- RX_IN low for 4 cycles at PRESCALE=8 (glitch) -> FSM returns to IDLE, no pulses; a following valid 0x55 frame is received correctly.
- Back-to-back frames 0xAA, 0xBB, 0x0C with no idle gap at PRESCALE=8 -> three DATA_VLD pulses spaced exactly 80 cycles apart (PAR_EN=0), correct bytes each time.
- RST asserted for 1 cycle in the middle of the DATA state -> all outputs 0 next cycle, no error pulse; the next clean frame 0xDD is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal oversampling
// ratios and the parity-type encoding used by both RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // PAR_TYP encoding: 0 selects even parity, 1 selects odd parity.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: counts oversampling edges,
// takes three samples around the bit centre and votes 2-of-3.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_s,
  input  logic                  run,
  input  logic                  start,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic                  maj
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]            smp_q, smp_d;
  logic                  maj_q, maj_d;
  logic [PRESCALE_W-1:0] half;

  assign half     = prescale >> 1;
  assign bit_done = run && (edge_cnt_q == (prescale - ONE));
  assign maj      = maj_q;

  // Edge counter, the three centre samples and the registered majority.
  always_comb begin
    edge_cnt_d = '0;
    smp_d      = smp_q;
    maj_d      = maj_q;
    if (run) begin
      edge_cnt_d = bit_done ? '0 : edge_cnt_q + ONE;
      if (edge_cnt_q == half - ONE) smp_d[0] = rx_s;
      if (edge_cnt_q == half)       smp_d[1] = rx_s;
      if (edge_cnt_q == half + ONE) smp_d[2] = rx_s;
      if (edge_cnt_q == half + TWO)
        maj_d = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    end else if (start) begin
      // The detect cycle itself is edge 0 of the start bit.
      edge_cnt_d = ONE;
    end
  end

  // Edge counter register; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) edge_cnt_q <= '0;
    else     edge_cnt_q <= edge_cnt_d;
  end

  // Sample and majority registers; always rewritten before use in a bit.
  always_ff @(posedge clk) begin
    smp_q <= smp_d;
    maj_q <= maj_d;
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: synchronizes RX_IN, walks the frame with a
// two-process FSM, checks parity and stop bit and emits one-cycle pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [1:0]            sync_q;
  logic                  rx_s;
  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_bad_q, par_bad_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  bit_done, maj;

  // Unsupported ratios fall back to 8x oversampling.
  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
    if (p == PRESCALE_W'(PRESCALE_16) || p == PRESCALE_W'(PRESCALE_32)) return p;
    return PRESCALE_W'(PRESCALE_8);
  endfunction

  assign rx_s = sync_q[1];

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk      (CLK),
    .rst      (RST),
    .rx_s     (rx_s),
    .run      (state_q != IDLE),
    .start    ((state_q == IDLE) && !rx_s),
    .prescale (presc_q),
    .bit_done (bit_done),
    .maj      (maj)
  );

  // Next-state, data capture, parity check and frame verdict.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    p_data_d   = p_data_q;
    data_vld_d = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          presc_d   = legal_prescale(PRESCALE);
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done) begin
          shreg_d[bit_cnt_q] = maj;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_bad_d = maj != ((^shreg_q) ^ (par_typ_q == PAR_ODD));
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d   = IDLE;
          stp_err_d = ~maj;
          par_err_d = par_bad_q;
          if (maj && !par_bad_q) begin
            data_vld_d = 1'b1;
            p_data_d   = shreg_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, synchronizer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      par_bad_q  <= 1'b0;
      p_data_q   <= '0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      par_bad_q  <= par_bad_d;
      p_data_q   <= p_data_d;
      data_vld_q <= data_vld_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  // Frame configuration and shift register; only meaningful inside a frame.
  always_ff @(posedge CLK) begin
    shreg_q   <= shreg_d;
    presc_q   <= presc_d;
    par_en_q  <= par_en_d;
    par_typ_q <= par_typ_d;
  end

  assign P_DATA   = p_data_q;
  assign DATA_VLD = data_vld_q;
  assign PAR_ERR  = par_err_q;
  assign STP_ERR  = stp_err_q;

endmodule
